// File: rtl/matvec_mult_seq.sv
// -----------------------------------------------------------------------------
// matvec_mult_seq
//
// Sequential matrix-vector multiplier (W * x) that feeds the bias-add stage of
// a feed-forward layer. The activation vector is latched on start, and one
// weight row is accepted per valid/ready handshake. Each row's dot product is
// accumulated by one serial MAC, one column per cycle. The result vector is
// presented once all active rows have been computed.
//
// Parameters
//   N     vector length / maximum row count (default `MAX_NEURONS)
//   W     signed element width
//   FRAC  fractional bits of the Q(W-FRAC).FRAC format
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         begin an operation (sampled only while idle)
//   rows_active   rows to compute; 0 or >N means N (sampled with start)
//   vector_in     activation vector x (latched on accepted start)
//   weight_row    one weight row, columns 0..N-1
//   weight_valid  weight_row is valid
//   weight_ready  block accepts a row this cycle
//   out           registered result vector
//   out_valid     out is complete
//   out_ready     downstream has consumed out
//   busy          high whenever not idle
//
// Build option
//   MATVEC_SATURATE_EN  defined: results clamp to the W-bit signed range.
//                       undefined: results keep the low W bits (wrap).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef MAX_NEURONS
`define MAX_NEURONS 4
`endif

module matvec_mult_seq #(
    parameter int N    = `MAX_NEURONS,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(N+1)-1:0]    rows_active,
    input  logic [N-1:0][W-1:0]       vector_in,
    input  logic [N-1:0][W-1:0]       weight_row,
    input  logic                      weight_valid,
    output logic                      weight_ready,
    output logic [N-1:0][W-1:0]       out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int RW = $clog2(N+1);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2*W;
    localparam int AW = 2*W + $clog2(N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [RW-1:0] N_ROWS   = RW'(N);
    localparam logic [CW-1:0] COL_LAST = CW'(N-1);

    logic [2:0]              state_reg, state_next;
    logic [N-1:0][W-1:0]     x_reg;
    logic [N-1:0][W-1:0]     row_reg;
    logic [RW-1:0]           r_total_reg;
    logic [RW-1:0]           r_reg;
    logic [CW-1:0]           col_reg;
    logic signed [AW-1:0]    acc_reg;

    logic [RW-1:0]           r_eff;
    logic signed [PW-1:0]    mul_a, mul_b, prod;
    logic signed [AW-1:0]    acc_sum;
    logic [W-1:0]            result;

    // Out-of-range row counts fall back to the full matrix.
    assign r_eff = (rows_active == '0 || rows_active > N_ROWS) ? N_ROWS : rows_active;

    // Operands are sign-extended to the full product width so the multiply
    // is exact (the product of two W-bit signed values always fits in 2W).
    assign mul_a   = PW'($signed(row_reg[col_reg]));
    assign mul_b   = PW'($signed(x_reg[col_reg]));
    assign prod    = mul_a * mul_b;
    assign acc_sum = acc_reg + AW'(prod);

`ifdef MATVEC_SATURATE_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [AW-1:0] shifted;
    assign shifted = acc_reg >>> FRAC;

    always_comb begin
        result = shifted[W-1:0];
        if (shifted > SAT_MAX) begin
            result = {1'b0, {(W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            result = {1'b1, {(W-1){1'b0}}};
        end
    end
`else
    // Arithmetic shift then truncation to W bits is just a bit window of acc.
    assign result = acc_reg[FRAC +: W];
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start)                 state_next = S_FETCH;
            S_FETCH: if (weight_valid)          state_next = S_MAC;
            S_MAC:   if (col_reg == COL_LAST)   state_next = S_WRITE;
            S_WRITE: state_next = (r_reg + RW'(1) == r_total_reg) ? S_DONE : S_FETCH;
            S_DONE:  if (out_ready)             state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            x_reg       <= '0;
            row_reg     <= '0;
            r_total_reg <= '0;
            r_reg       <= '0;
            col_reg     <= '0;
            acc_reg     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        x_reg       <= vector_in;
                        r_total_reg <= r_eff;
                        r_reg       <= '0;
                    end
                end
                S_FETCH: begin
                    if (weight_valid) begin
                        row_reg <= weight_row;
                        col_reg <= '0;
                        acc_reg <= '0;
                    end
                end
                S_MAC: begin
                    acc_reg <= acc_sum;
                    if (col_reg != COL_LAST) begin
                        col_reg <= col_reg + CW'(1);
                    end
                end
                S_WRITE: begin
                    r_reg <= r_reg + RW'(1);
                end
                default: ;
            endcase
        end
    end

    // One register per result element: cleared on reset and on an accepted
    // start, loaded when its row finishes. Rows beyond R are never loaded,
    // so they remain zero.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_out
            logic [W-1:0] elem_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    elem_reg <= '0;
                end else if (state_reg == S_IDLE && start) begin
                    elem_reg <= '0;
                end else if (state_reg == S_WRITE && r_reg == RW'(gi)) begin
                    elem_reg <= result;
                end
            end

            assign out[gi] = elem_reg;
        end
    endgenerate

    assign weight_ready = (state_reg == S_FETCH);
    assign out_valid    = (state_reg == S_DONE);
    assign busy         = (state_reg != S_IDLE);

endmodule
